// File: rtl/sauria_addr_pkg.sv
// -----------------------------------------------------------------------------
// sauria_addr_pkg
// Shared definitions for SAURIA's internal address router: the default region
// table (base/mask pairs packed LSB-first, region 0 in bits [31:0]), the
// target id type and the data word returned for decode-error responses.
// -----------------------------------------------------------------------------
package sauria_addr_pkg;

    localparam int RGN_N  = 8;
    localparam int RGN_AW = 32;

    typedef logic [3:0] tgt_id_t;

    // Region indices in table order; lower index wins on overlap.
    typedef enum logic [3:0] {
        RGN_REGS  = 4'd0,
        RGN_CON   = 4'd1,
        RGN_ACT   = 4'd2,
        RGN_WEI   = 4'd3,
        RGN_OUT   = 4'd4,
        RGN_SRAMA = 4'd5,
        RGN_SRAMB = 4'd6,
        RGN_SRAMC = 4'd7
    } rgn_e;

    localparam logic [31:0] CFG_MASK  = 32'h000F_FE00;
    localparam logic [31:0] SRAM_MASK = 32'h000F_0000;

    localparam logic [RGN_N*RGN_AW-1:0] RGN_BASE = {
        32'h0003_0000,  // SRAMC
        32'h0002_0000,  // SRAMB
        32'h0001_0000,  // SRAMA
        32'h0000_0800,  // OUT
        32'h0000_0600,  // WEI
        32'h0000_0400,  // ACT
        32'h0000_0200,  // CON
        32'h0000_0000   // REGS
    };

    localparam logic [RGN_N*RGN_AW-1:0] RGN_MASK = {
        SRAM_MASK, SRAM_MASK, SRAM_MASK,
        CFG_MASK, CFG_MASK, CFG_MASK, CFG_MASK, CFG_MASK
    };

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/sauria_addr_decode.sv
// -----------------------------------------------------------------------------
// sauria_addr_decode
// Combinational first-match region decoder.
//   addr   : incoming host address
//   id     : index of the lowest-numbered matching region (0 when none match)
//   miss   : no region matched
//   hit    : one-hot of the winning region (all zero on miss)
//   offset : addr with the winning region's select bits cleared; the full
//            address is passed through on a miss
// -----------------------------------------------------------------------------
module sauria_addr_decode
    import sauria_addr_pkg::*;
#(
    parameter int unsigned ADR_W = 32,
    parameter int unsigned N_TGT = 8,
    parameter logic [N_TGT*ADR_W-1:0] TGT_BASE = RGN_BASE,
    parameter logic [N_TGT*ADR_W-1:0] TGT_MASK = RGN_MASK
) (
    input  logic [ADR_W-1:0] addr,
    output tgt_id_t          id,
    output logic             miss,
    output logic [N_TGT-1:0] hit,
    output logic [ADR_W-1:0] offset
);

    logic [N_TGT-1:0] raw_hit;

    always_comb begin
        raw_hit = '0;
        for (int k = 0; k < N_TGT; k++) begin
            raw_hit[k] = ((addr & TGT_MASK[k*ADR_W +: ADR_W]) == TGT_BASE[k*ADR_W +: ADR_W]);
        end
    end

    // Walk upward and latch the first match; later matches are shadowed.
    always_comb begin
        id     = '0;
        miss   = 1'b1;
        hit    = '0;
        offset = addr;
        for (int k = 0; k < N_TGT; k++) begin
            if (raw_hit[k] && miss) begin
                miss   = 1'b0;
                id     = tgt_id_t'(k);
                hit[k] = 1'b1;
                offset = addr & ~TGT_MASK[k*ADR_W +: ADR_W];
            end
        end
    end

endmodule

// File: rtl/sauria_addr_router.sv
// -----------------------------------------------------------------------------
// sauria_addr_router
// Routes one OBI-style host port to N_TGT target ports using a base/mask
// region table with first-match priority and offset stripping. Outstanding
// transactions are counted and restricted to a single target at a time so
// responses come back in order.
//
// Host port   : i_req/o_gnt, i_addr, i_we, i_be, i_wdata, o_rvalid, o_rdata, o_err
// Target port : o_tgt_req (one-hot), i_tgt_gnt, o_tgt_addr (offset),
//               o_tgt_we/o_tgt_be/o_tgt_wdata (forwarded), i_tgt_rvalid, i_tgt_rdata
// Status      : o_outst_cnt, o_busy
//
// Handshake: a request transfers on a cycle where i_req && o_gnt; the host
// holds i_req and its fields stable until then. A response transfers on every
// cycle o_rvalid is high (no back-pressure on the response channel).
//
// Build option SAURIA_ADDR_ROUTER_ERR_RESP_EN: when defined, unmapped
// addresses are granted locally and answered one cycle later with o_err=1 and
// ERR_RDATA. When undefined, unmapped addresses go to target 0 unchanged.
// -----------------------------------------------------------------------------
module sauria_addr_router
    import sauria_addr_pkg::*;
#(
    parameter int unsigned ADR_W     = 32,
    parameter int unsigned DAT_W     = 32,
    parameter int unsigned N_TGT     = 8,
    parameter int unsigned MAX_OUTST = 4,
    parameter logic [N_TGT*ADR_W-1:0] TGT_BASE = RGN_BASE,
    parameter logic [N_TGT*ADR_W-1:0] TGT_MASK = RGN_MASK
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_req,
    output logic                   o_gnt,
    input  logic [ADR_W-1:0]       i_addr,
    input  logic                   i_we,
    input  logic [DAT_W/8-1:0]     i_be,
    input  logic [DAT_W-1:0]       i_wdata,
    output logic                   o_rvalid,
    output logic [DAT_W-1:0]       o_rdata,
    output logic                   o_err,
    output logic [N_TGT-1:0]       o_tgt_req,
    input  logic [N_TGT-1:0]       i_tgt_gnt,
    output logic [ADR_W-1:0]       o_tgt_addr,
    output logic                   o_tgt_we,
    output logic [DAT_W/8-1:0]     o_tgt_be,
    output logic [DAT_W-1:0]       o_tgt_wdata,
    input  logic [N_TGT-1:0]       i_tgt_rvalid,
    input  logic [N_TGT*DAT_W-1:0] i_tgt_rdata,
    output logic [3:0]             o_outst_cnt,
    output logic                   o_busy
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    // Tracking state
    logic [3:0] cnt;
    tgt_id_t    cur_id;
    logic       cur_unm;   // outstanding traffic is the local error responder
    logic       err_pend;  // error response due this cycle

    // Decode
    tgt_id_t          dec_id;
    logic             dec_miss;
    logic [N_TGT-1:0] dec_hit;

    sauria_addr_decode #(
        .ADR_W    (ADR_W),
        .N_TGT    (N_TGT),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_decode (
        .addr   (i_addr),
        .id     (dec_id),
        .miss   (dec_miss),
        .hit    (dec_hit),
        .offset (o_tgt_addr)
    );

    // Routed id / unmapped flag after the build option is applied. A miss
    // already decodes to id 0, so the fallback route needs no extra mux.
    tgt_id_t          rt_id;
    logic             rt_unm;
    logic [N_TGT-1:0] route_vec;

    always_comb begin
        rt_id = dec_id;
`ifdef SAURIA_ADDR_ROUTER_ERR_RESP_EN
        rt_unm = dec_miss;
`else
        rt_unm = 1'b0;
`endif
        route_vec = dec_miss ? N_TGT'(1) : dec_hit;
    end

    // Response path
    logic             tgt_rv;
    logic [DAT_W-1:0] tgt_rd;
    logic             rsp_tgt;
    logic             rsp;

    always_comb begin
        tgt_rv = 1'b0;
        tgt_rd = '0;
        for (int k = 0; k < N_TGT; k++) begin
            if (tgt_id_t'(k) == cur_id) begin
                tgt_rv = i_tgt_rvalid[k];
                tgt_rd = i_tgt_rdata[k*DAT_W +: DAT_W];
            end
        end
        // Responses from other targets, or with nothing outstanding, are dropped.
        rsp_tgt = (cnt != 4'd0) && !cur_unm && tgt_rv;
        rsp     = rsp_tgt || err_pend;
    end

    always_comb begin
        o_rvalid = rsp;
        if (err_pend) begin
            o_rdata = DAT_W'(ERR_RDATA);
        end else if (rsp_tgt) begin
            o_rdata = tgt_rd;
        end else begin
            o_rdata = '0;
        end
`ifdef SAURIA_ADDR_ROUTER_ERR_RESP_EN
        o_err = err_pend;
`else
        o_err = 1'b0;
`endif
    end

    // Issue path
    logic final_rsp;
    logic room_ok;
    logic tgt_ok;
    logic allowed;
    logic sel_gnt;
    logic hs;

    always_comb begin
        final_rsp = rsp && (cnt == 4'd1);
        // A response in the same cycle frees a slot, so a full pipe can still issue.
        room_ok   = (cnt < MAX_CNT) || rsp;
        if ((cnt == 4'd0) || final_rsp) begin
            tgt_ok = 1'b1;
        end else if (rt_unm) begin
            tgt_ok = cur_unm;
        end else begin
            tgt_ok = !cur_unm && (rt_id == cur_id);
        end
        allowed = room_ok && tgt_ok;
        sel_gnt = |(i_tgt_gnt & route_vec);

        o_tgt_req = '0;
        o_gnt     = 1'b0;
        if (allowed) begin
            if (rt_unm) begin
                o_gnt = i_req;
            end else begin
                o_tgt_req = i_req ? route_vec : '0;
                o_gnt     = sel_gnt;
            end
        end
        hs = i_req && o_gnt;
    end

    assign o_tgt_we    = i_we;
    assign o_tgt_be    = i_be;
    assign o_tgt_wdata = i_wdata;

    // Tracking registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt      <= 4'd0;
            cur_id   <= '0;
            cur_unm  <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            if (hs) begin
                cur_id  <= rt_id;
                cur_unm <= rt_unm;
            end
            err_pend <= hs && rt_unm;
            if (hs && !rsp) begin
                cnt <= cnt + 4'd1;
            end else if (!hs && rsp) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign o_outst_cnt = cnt;
    assign o_busy      = (cnt != 4'd0);

endmodule

// File: tb/tb_sauria_addr_router.sv
module tb_sauria_addr_router;
    import sauria_addr_pkg::*;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int N_TGT = 8;
    localparam logic [N_TGT*ADR_W-1:0] OVL_MASK = {RGN_MASK[N_TGT*ADR_W-1:ADR_W], 32'h000F_FC00};

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main DUT signals
    logic                   req = 1'b0;
    logic                   gnt;
    logic [ADR_W-1:0]       addr = '0;
    logic                   we = 1'b0;
    logic [DAT_W/8-1:0]     be = '0;
    logic [DAT_W-1:0]       wdata = '0;
    logic                   rvalid;
    logic [DAT_W-1:0]       rdata;
    logic                   err;
    logic [N_TGT-1:0]       tgt_req;
    logic [N_TGT-1:0]       tgt_gnt = '0;
    logic [ADR_W-1:0]       tgt_addr;
    logic                   tgt_we;
    logic [DAT_W/8-1:0]     tgt_be;
    logic [DAT_W-1:0]       tgt_wdata;
    logic [N_TGT-1:0]       tgt_rvalid = '0;
    logic [N_TGT*DAT_W-1:0] tgt_rdata = '0;
    logic [3:0]             outst_cnt;
    logic                   busy;

    // Overlap-table instance signals
    logic                   o2_req = 1'b0;
    logic                   o2_gnt;
    logic [ADR_W-1:0]       o2_addr = '0;
    logic                   o2_rvalid;
    logic [DAT_W-1:0]       o2_rdata;
    logic                   o2_err;
    logic [N_TGT-1:0]       o2_tgt_req;
    logic [N_TGT-1:0]       o2_tgt_gnt = '0;
    logic [ADR_W-1:0]       o2_tgt_addr;
    logic                   o2_tgt_we;
    logic [DAT_W/8-1:0]     o2_tgt_be;
    logic [DAT_W-1:0]       o2_tgt_wdata;
    logic [3:0]             o2_outst_cnt;
    logic                   o2_busy;

    sauria_addr_router u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .o_gnt        (gnt),
        .i_addr       (addr),
        .i_we         (we),
        .i_be         (be),
        .i_wdata      (wdata),
        .o_rvalid     (rvalid),
        .o_rdata      (rdata),
        .o_err        (err),
        .o_tgt_req    (tgt_req),
        .i_tgt_gnt    (tgt_gnt),
        .o_tgt_addr   (tgt_addr),
        .o_tgt_we     (tgt_we),
        .o_tgt_be     (tgt_be),
        .o_tgt_wdata  (tgt_wdata),
        .i_tgt_rvalid (tgt_rvalid),
        .i_tgt_rdata  (tgt_rdata),
        .o_outst_cnt  (outst_cnt),
        .o_busy       (busy)
    );

    sauria_addr_router #(.TGT_MASK(OVL_MASK)) u_ovl (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (o2_req),
        .o_gnt        (o2_gnt),
        .i_addr       (o2_addr),
        .i_we         (we),
        .i_be         (be),
        .i_wdata      (wdata),
        .o_rvalid     (o2_rvalid),
        .o_rdata      (o2_rdata),
        .o_err        (o2_err),
        .o_tgt_req    (o2_tgt_req),
        .i_tgt_gnt    (o2_tgt_gnt),
        .o_tgt_addr   (o2_tgt_addr),
        .o_tgt_we     (o2_tgt_we),
        .o_tgt_be     (o2_tgt_be),
        .o_tgt_wdata  (o2_tgt_wdata),
        .i_tgt_rvalid ('0),
        .i_tgt_rdata  ('0),
        .o_outst_cnt  (o2_outst_cnt),
        .o_busy       (o2_busy)
    );

    // Scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    logic [DAT_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drivers: every input change happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [ADR_W-1:0] a, input logic w, input logic [N_TGT-1:0] g);
        req     = 1'b1;
        addr    = a;
        we      = w;
        be      = 4'hF;
        wdata   = {8'hA5, a[23:0]};
        tgt_gnt = g;
    endtask

    task automatic idle_req();
        req     = 1'b0;
        addr    = '0;
        we      = 1'b0;
        be      = '0;
        wdata   = '0;
        tgt_gnt = '0;
    endtask

    task automatic set_rdata(input int k, input logic [DAT_W-1:0] d);
        tgt_rdata[k*DAT_W +: DAT_W] = d;
    endtask

    // Pops the next expected read word and compares against o_rdata.
    task automatic check_rsp(input string tag);
        logic [DAT_W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'(rdata), 64'(e));
        end
    endtask

    initial begin
        // Reset
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_cnt",    64'(outst_cnt), 64'd0);
        check("rst_busy",   64'(busy),      64'd0);
        check("rst_gnt",    64'(gnt),       64'd0);
        check("rst_tgtreq", 64'(tgt_req),   64'd0);
        check("rst_rvalid", 64'(rvalid),    64'd0);
        check("rst_rdata",  64'(rdata),     64'd0);
        check("rst_err",    64'(err),       64'd0);
        tick();

        // 1: read 0x0002_0010 -> SRAMB (target 6), offset 0x10
        set_rdata(0, 32'h1111_0000);
        set_rdata(6, 32'hCAFE_0006);
        drive_req(32'h0002_0010, 1'b0, 8'h40);
        #1;
        check("rd_tgtreq",  64'(tgt_req),   64'h40);
        check("rd_tgtaddr", 64'(tgt_addr),  64'h10);
        check("rd_gnt",     64'(gnt),       64'd1);
        check("rd_fwd_we",  64'(tgt_we),    64'd0);
        check("rd_fwd_wd",  64'(tgt_wdata), 64'hA502_0010);
        exp_q.push_back(32'hCAFE_0006);
        tick();
        idle_req();
        check("rd_cnt1", 64'(outst_cnt), 64'd1);
        check("rd_busy", 64'(busy),      64'd1);
        tick();
        check("rd_wait_rvalid", 64'(rvalid), 64'd0);
        tgt_rvalid = 8'h40;
        #1;
        check("rd_rvalid", 64'(rvalid), 64'd1);
        check("rd_err",    64'(err),    64'd0);
        check_rsp("rd_rdata");
        tick();
        tgt_rvalid = '0;
        check("rd_cnt0", 64'(outst_cnt), 64'd0);

        // 2: four back-to-back writes to SRAMA, responses withheld
        for (int i = 0; i < 4; i++) begin
            drive_req(32'h0001_0000 + 32'(i * 4), 1'b1, 8'h20);
            #1;
            check($sformatf("wr%0d_gnt", i), 64'(gnt), 64'd1);
            check($sformatf("wr%0d_addr", i), 64'(tgt_addr), 64'(i * 4));
            tick();
        end
        check("wr_cnt4", 64'(outst_cnt), 64'd4);
        drive_req(32'h0001_0010, 1'b1, 8'h20);
        #1;
        check("wr5_stall_gnt", 64'(gnt),     64'd0);
        check("wr5_stall_req", 64'(tgt_req), 64'd0);
        tick();
        check("wr5_still_cnt4", 64'(outst_cnt), 64'd4);
        check("wr5_still_gnt",  64'(gnt),       64'd0);
        tgt_rvalid = 8'h20;
        #1;
        check("wr5_gnt_on_rsp", 64'(gnt),    64'd1);
        check("wr5_rvalid",     64'(rvalid), 64'd1);
        tick();
        idle_req();
        tgt_rvalid = '0;
        check("wr5_cnt_hold", 64'(outst_cnt), 64'd4);
        tgt_rvalid = 8'h20;
        repeat (4) tick();
        tgt_rvalid = '0;
        check("wr_drained", 64'(outst_cnt), 64'd0);

        // 3: CON access while two SRAMC transactions are outstanding
        for (int i = 0; i < 2; i++) begin
            drive_req(32'h0003_0000 + 32'(i * 4), 1'b0, 8'h80);
            tick();
        end
        check("sw_cnt2", 64'(outst_cnt), 64'd2);
        drive_req(32'h0000_0200, 1'b1, 8'h02);
        #1;
        check("sw_stall_gnt", 64'(gnt),     64'd0);
        check("sw_stall_req", 64'(tgt_req), 64'd0);
        tick();
        tgt_rvalid = 8'h80;
        #1;
        check("sw_stall_cnt2", 64'(gnt), 64'd0);
        tick();
        check("sw_cnt1", 64'(outst_cnt), 64'd1);
        check("sw_gnt_final", 64'(gnt),      64'd1);
        check("sw_req_con",   64'(tgt_req),  64'h02);
        check("sw_addr_con",  64'(tgt_addr), 64'h0);
        tick();
        idle_req();
        tgt_rvalid = 8'h80;
        #1;
        check("sw_cnt_after", 64'(outst_cnt), 64'd1);
        check("sw_stray_rv",  64'(rvalid),    64'd0);
        tgt_rvalid = 8'h02;
        tick();
        tgt_rvalid = '0;
        check("sw_drained", 64'(outst_cnt), 64'd0);

        // 4: unmapped read 0x0005_0000
`ifdef SAURIA_ADDR_ROUTER_ERR_RESP_EN
        drive_req(32'h0005_0000, 1'b0, 8'h00);
        #1;
        check("um_gnt",    64'(gnt),     64'd1);
        check("um_tgtreq", 64'(tgt_req), 64'd0);
        exp_q.push_back(ERR_RDATA);
        tick();
        idle_req();
        check("um_rvalid", 64'(rvalid),    64'd1);
        check("um_err",    64'(err),       64'd1);
        check("um_cnt1",   64'(outst_cnt), 64'd1);
        check_rsp("um_rdata");
        tick();
        check("um_cnt0",   64'(outst_cnt), 64'd0);
        check("um_rv_off", 64'(rvalid),    64'd0);
`else
        drive_req(32'h0005_0000, 1'b0, 8'h01);
        #1;
        check("um_tgtreq",  64'(tgt_req),  64'h01);
        check("um_tgtaddr", 64'(tgt_addr), 64'h0005_0000);
        check("um_gnt",     64'(gnt),      64'd1);
        exp_q.push_back(32'h1111_0000);
        tick();
        idle_req();
        check("um_cnt1", 64'(outst_cnt), 64'd1);
        tgt_rvalid = 8'h01;
        #1;
        check("um_rvalid", 64'(rvalid), 64'd1);
        check("um_err",    64'(err),    64'd0);
        check_rsp("um_rdata");
        tick();
        tgt_rvalid = '0;
        check("um_cnt0", 64'(outst_cnt), 64'd0);
`endif

        // 5: reset with three SRAMB reads outstanding
        for (int i = 0; i < 3; i++) begin
            drive_req(32'h0002_0100 + 32'(i * 4), 1'b0, 8'h40);
            tick();
        end
        idle_req();
        check("mr_cnt3", 64'(outst_cnt), 64'd3);
        rst = 1'b1;
        tick();
        check("mr_cnt",    64'(outst_cnt), 64'd0);
        check("mr_busy",   64'(busy),      64'd0);
        check("mr_gnt",    64'(gnt),       64'd0);
        check("mr_tgtreq", 64'(tgt_req),   64'd0);
        check("mr_rvalid", 64'(rvalid),    64'd0);
        check("mr_rdata",  64'(rdata),     64'd0);
        rst = 1'b0;
        tgt_rvalid = 8'h40;
        #1;
        check("mr_late_rv", 64'(rvalid), 64'd0);
        check("mr_late_rd", 64'(rdata),  64'd0);
        tick();
        tgt_rvalid = '0;
        check("mr_no_underflow", 64'(outst_cnt), 64'd0);

        // 6: decode spot checks and overlapping table priority
        drive_req(32'h0000_0404, 1'b0, 8'h00);
        #1;
        check("dec_act_req",  64'(tgt_req),  64'h04);
        check("dec_act_addr", 64'(tgt_addr), 64'h4);
        addr = 32'h0000_0200;
        #1;
        check("dec_con_req", 64'(tgt_req), 64'h02);
        idle_req();
        o2_req     = 1'b1;
        o2_addr    = 32'h0000_0200;
        o2_tgt_gnt = 8'h01;
        #1;
        check("ovl_req",  64'(o2_tgt_req),  64'h01);
        check("ovl_addr", 64'(o2_tgt_addr), 64'h200);
        check("ovl_gnt",  64'(o2_gnt),      64'd1);
        o2_req     = 1'b0;
        o2_tgt_gnt = '0;
        tick();

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
